// File: rtl/ysyx_040729_exe_mul_ctrl.sv
// EXE-stage front end for the shared iterative multiplier: issues the op, collects the
// product halves, forms the RV64M result and holds it until writeback takes it.
//
// state | meaning
// IDLE  | ready for a new multiply op
// ISSUE | request presented to the multiplier, waiting for mul_ready
// WAIT  | multiplier busy, waiting for mul_out_valid
// HOLD  | result valid, waiting for wb_ready
module ysyx_040729_exe_mul_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [2:0]      op_type,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  input  logic            wb_ready,
  output logic            op_ready,
  output logic            stall,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic            mul_valid,
  output logic            mul_flush,
  output logic            mulw,
  output logic [1:0]      mul_signed,
  output logic [XLEN-1:0] multiplicand,
  output logic [XLEN-1:0] multiplier,
  input  logic            mul_ready,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] result_hi,
  input  logic [XLEN-1:0] result_lo
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] res_q, res_d;

  logic [2:0]      op_norm;
  logic            src_zero;
  logic [XLEN-1:0] res_sel;

  // Reserved encodings collapse to MUL so every later decode sees a legal op.
  assign op_norm = (op_type > OP_MULW) ? OP_MUL : op_type;

  // A zero operand makes the product zero, so the multiplier is not needed.
  always_comb begin
    if (op_norm == OP_MULW) begin
      src_zero = (src1[31:0] == 32'd0) || (src2[31:0] == 32'd0);
    end else begin
      src_zero = (src1 == '0) || (src2 == '0);
    end
  end

  always_comb begin
    case (op_q)
      OP_MUL:  res_sel = result_lo;
      OP_MULW: res_sel = {{(XLEN-32){result_lo[31]}}, result_lo[31:0]};
      default: res_sel = result_hi;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      src1_q  <= '0;
      src2_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    res_d   = res_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            op_d   = op_norm;
            src1_d = src1;
            src2_d = src2;
            if (src_zero) begin
              res_d   = '0;
              state_d = S_HOLD;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mul_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mul_out_valid) begin
            res_d   = res_sel;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (wb_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (op_q)
      OP_MULHSU: mul_signed = 2'b10;
      OP_MULHU:  mul_signed = 2'b00;
      default:   mul_signed = 2'b11;
    endcase
  end

  assign op_ready     = (state_q == S_IDLE);
  assign res_valid    = (state_q == S_HOLD);
  assign res_data     = res_q;
  assign mul_valid    = (state_q == S_ISSUE);
  assign mul_flush    = flush && ((state_q == S_ISSUE) || (state_q == S_WAIT));
  assign mulw         = (op_q == OP_MULW);
  assign multiplicand = src1_q;
  assign multiplier   = src2_q;

  assign stall = ((state_q == S_IDLE) && op_valid && !flush) ||
                 (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                 ((state_q == S_HOLD) && !wb_ready);

endmodule

// File: tb/tb_ysyx_040729_exe_mul_ctrl.sv
// Directed bench for the multiply controller: behavioural multiplier responder,
// RV64M result model and a per-cycle compare process.
module tb_ysyx_040729_exe_mul_ctrl;

  logic        clock;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [63:0] src1, src2;
  logic        flush, wb_ready;
  logic        op_ready, stall, res_valid;
  logic [63:0] res_data;
  logic        mul_valid, mul_flush, mulw;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand, multiplier;
  logic        mul_ready, mul_out_valid;
  logic [63:0] result_hi, result_lo;

  int n_cmp = 0;
  int n_err = 0;

  // responder knobs
  int rdy_wait = 0;
  int lat      = 0;
  int stray    = 0;

  // model of the op currently in flight
  logic [2:0]  mdl_op = 3'd0;
  logic [63:0] mdl_a  = 64'd0;
  logic [63:0] mdl_b  = 64'd0;
  bit          mdl_short  = 1'b0;
  bit          mdl_no_res = 1'b0;

  ysyx_040729_exe_mul_ctrl #(.XLEN(64)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_type(op_type),
    .src1(src1), .src2(src2), .flush(flush), .wb_ready(wb_ready),
    .op_ready(op_ready), .stall(stall), .res_valid(res_valid), .res_data(res_data),
    .mul_valid(mul_valid), .mul_flush(mul_flush), .mulw(mulw), .mul_signed(mul_signed),
    .multiplicand(multiplicand), .multiplier(multiplier), .mul_ready(mul_ready),
    .mul_out_valid(mul_out_valid), .result_hi(result_hi), .result_lo(result_lo)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Architectural RV64M result straight from the instruction definition.
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  w;
    case (op)
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
      3'd4: begin
        w = {32'd0, a[31:0]} * {32'd0, b[31:0]};
        return {{32{w[31]}}, w[31:0]};
      end
      default: return a * b;
    endcase
  endfunction

  function automatic logic [1:0] ref_sgn(input logic [2:0] op);
    case (op)
      3'd2:    return 2'b10;
      3'd3:    return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [127:0] full_prod(input logic [1:0] sg, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] xa, xb;
    xa = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
    xb = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
    return xa * xb;
  endfunction

  // Multiplier responder: drives its side on the falling edge.
  initial begin : responder
    bit           busy;
    int           cnt;
    logic [127:0] prod;
    busy = 1'b0; cnt = 0; prod = '0;
    mul_ready = 1'b0; mul_out_valid = 1'b0; result_hi = '0; result_lo = '0;
    forever begin
      @(negedge clock);
      mul_out_valid = 1'b0;
      if (!reset) begin
        busy = 1'b0;
        mul_ready = 1'b0;
      end else if (busy) begin
        mul_ready = 1'b0;
        if (cnt == 0) begin
          mul_out_valid = 1'b1;
          result_hi = prod[127:64];
          result_lo = prod[63:0];
          busy = 1'b0;
        end else if (mul_flush) begin
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (mul_valid && !mul_flush) begin
        if (rdy_wait > 0) begin
          rdy_wait--;
          mul_ready = 1'b0;
        end else begin
          mul_ready = 1'b1;
          busy = 1'b1;
          cnt = lat;
          prod = full_prod(mul_signed, multiplicand, multiplier);
        end
      end else begin
        mul_ready = 1'b0;
        if (stray > 0) begin
          stray--;
          mul_out_valid = 1'b1;
          result_hi = 64'hDEAD_BEEF_DEAD_BEEF;
          result_lo = 64'hBAAD_F00D_BAAD_F00D;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      if (mul_valid) begin
        chk("mdl_no_mul_on_shortcut", 64'(mdl_short), 64'd0);
        chk("mdl_mulw", 64'(mulw), 64'(mdl_op == 3'd4));
        chk("mdl_mul_signed", 64'(mul_signed), 64'(ref_sgn(mdl_op)));
        chk("mdl_multiplicand", multiplicand, mdl_a);
        chk("mdl_multiplier", multiplier, mdl_b);
      end
      if (res_valid) begin
        if (mdl_no_res) chk("mdl_unexpected_res_valid", 64'd1, 64'd0);
        else            chk("mdl_res_data", res_data, ref_res(mdl_op, mdl_a, mdl_b));
      end
    end
  end

  task automatic set_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    mdl_op = (op > 3'd4) ? 3'd0 : op;
    mdl_a  = a;
    mdl_b  = b;
    mdl_short = (mdl_op == 3'd4) ? (a[31:0] == 32'd0 || b[31:0] == 32'd0)
                                 : (a == 64'd0 || b == 64'd0);
    mdl_no_res = 1'b0;
  endtask

  task automatic present(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    @(posedge clock); #1;
    op_valid = 1'b1; op_type = op; src1 = a; src2 = b;
  endtask

  task automatic drop_op();
    @(posedge clock); #1;
    op_valid = 1'b0;
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
  endtask

  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input logic [1:0] esg, input logic ew,
                        input int rw, input int lt, input int wbw);
    int  n, mv, exp_n;
    bit  seen;
    rdy_wait = rw; lat = lt;
    set_model(op, a, b);
    present(op, a, b);
    @(negedge clock);
    chk("accept_op_ready", 64'(op_ready), 64'd1);
    chk("accept_stall", 64'(stall), 64'd1);
    drop_op();
    n = 0; mv = 0; seen = 1'b0;
    do begin
      @(negedge clock);
      n++;
      if (mul_valid) begin
        mv++;
        if (!seen) begin
          chk("issue_mul_signed", 64'(mul_signed), 64'(esg));
          chk("issue_mulw", 64'(mulw), 64'(ew));
        end
        seen = 1'b1;
      end
    end while (!res_valid && n < 60);
    exp_n = mdl_short ? 1 : rw + lt + 3;
    chk("res_latency", 64'(n), 64'(exp_n));
    chk("mul_valid_cycles", 64'(mv), mdl_short ? 64'd0 : 64'(rw + 1));
    chk("res_data", res_data, exp);
    chk("hold_stall", 64'(stall), 64'd1);
    if (wbw >= 3) stray = 2;
    for (int i = 0; i < wbw; i++) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_res_data", res_data, exp);
      chk("hold_stall_bp", 64'(stall), 64'd1);
    end
    @(posedge clock); #1; wb_ready = 1'b1;
    @(negedge clock);
    chk("release_stall", 64'(stall), 64'd0);
    chk("release_op_ready", 64'(op_ready), 64'd0);
    @(posedge clock); #1; wb_ready = 1'b0;
    @(negedge clock);
    chk("after_res_valid", 64'(res_valid), 64'd0);
    chk("after_op_ready", 64'(op_ready), 64'd1);
  endtask

  task automatic count_res(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (res_valid) hits++;
    end
  endtask

  initial begin : main
    int hits;
    reset = 1'b0; op_valid = 1'b0; op_type = 3'd0; src1 = '0; src2 = '0;
    flush = 1'b0; wb_ready = 1'b0;
    #3;
    chk("rst_op_ready", 64'(op_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_mul_valid", 64'(mul_valid), 64'd0);
    chk("rst_mul_flush", 64'(mul_flush), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_op(3'd0, 64'd3, 64'd5, 64'd15, 2'b11, 1'b0, 0, 2, 0);
    run_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 1, 3, 1);
    run_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 2'b00, 1'b0, 0, 0, 0);
    run_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 2, 1, 0);
    run_op(3'd4, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2'b11, 1'b1, 0, 4, 3);
    run_op(3'd6, 64'd3, 64'd5, 64'd15, 2'b11, 1'b0, 0, 1, 0);
    run_op(3'd0, 64'h1234, 64'd0, 64'd0, 2'b11, 1'b0, 0, 0, 0);
    run_op(3'd4, 64'hFFFF_FFFF_0000_0000, 64'd5, 64'd0, 2'b11, 1'b1, 0, 0, 3);

    // stalled issue, then flush while waiting
    rdy_wait = 4; lat = 10;
    set_model(3'd0, 64'd9, 64'd9);
    mdl_no_res = 1'b1;
    present(3'd0, 64'd9, 64'd9);
    drop_op();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("issue_hold_mul_valid", 64'(mul_valid), 64'd1);
      chk("issue_hold_multiplicand", multiplicand, 64'd9);
      chk("issue_hold_multiplier", multiplier, 64'd9);
    end
    @(negedge clock);
    chk("wait_mul_valid_low", 64'(mul_valid), 64'd0);
    chk("wait_mul_flush_low", 64'(mul_flush), 64'd0);
    @(posedge clock); #1; flush = 1'b1;
    @(negedge clock);
    chk("wait_flush_mul_flush", 64'(mul_flush), 64'd1);
    @(posedge clock); #1; flush = 1'b0;
    @(negedge clock);
    chk("post_flush_mul_flush", 64'(mul_flush), 64'd0);
    chk("post_flush_op_ready", 64'(op_ready), 64'd1);
    chk("post_flush_stall", 64'(stall), 64'd0);
    count_res(15, hits);
    chk("flushed_no_res", 64'(hits), 64'd0);
    run_op(3'd0, 64'd7, 64'd6, 64'd42, 2'b11, 1'b0, 0, 3, 0);

    // flush alongside op_valid in IDLE drops the op
    set_model(3'd0, 64'd3, 64'd5);
    mdl_no_res = 1'b1;
    @(posedge clock); #1;
    op_valid = 1'b1; flush = 1'b1; op_type = 3'd0; src1 = 64'd3; src2 = 64'd5;
    @(negedge clock);
    chk("idle_flush_stall", 64'(stall), 64'd0);
    chk("idle_flush_mul_flush", 64'(mul_flush), 64'd0);
    @(posedge clock); #1; op_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    chk("idle_flush_op_ready", 64'(op_ready), 64'd1);
    chk("idle_flush_mul_valid", 64'(mul_valid), 64'd0);
    chk("idle_flush_res_valid", 64'(res_valid), 64'd0);

    // flush in the same cycle the result arrives
    rdy_wait = 0; lat = 2;
    set_model(3'd0, 64'd3, 64'd3);
    mdl_no_res = 1'b1;
    present(3'd0, 64'd3, 64'd3);
    drop_op();
    repeat (3) @(negedge clock);
    @(posedge clock); #1; flush = 1'b1;
    @(negedge clock);
    chk("race_mul_out_valid", 64'(mul_out_valid), 64'd1);
    chk("race_mul_flush", 64'(mul_flush), 64'd1);
    @(posedge clock); #1; flush = 1'b0;
    count_res(5, hits);
    chk("race_no_res", 64'(hits), 64'd0);
    chk("race_op_ready", 64'(op_ready), 64'd1);

    // stray result pulses while idle
    stray = 2;
    count_res(4, hits);
    chk("stray_idle_no_res", 64'(hits), 64'd0);

    // asynchronous reset in the middle of WAIT
    rdy_wait = 0; lat = 20;
    set_model(3'd0, 64'd11, 64'd13);
    mdl_no_res = 1'b1;
    present(3'd0, 64'd11, 64'd13);
    drop_op();
    repeat (4) @(negedge clock);
    chk("pre_reset_stall", 64'(stall), 64'd1);
    #2; reset = 1'b0; #1;
    chk("arst_op_ready", 64'(op_ready), 64'd1);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_mul_valid", 64'(mul_valid), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_res_data", res_data, 64'd0);
    @(negedge clock); #1; reset = 1'b1;
    run_op(3'd1, 64'h8000_0000_0000_0000, 64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 2'b11, 1'b0, 1, 1, 0);
    run_op(3'd3, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 2'b00, 1'b0, 0, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/ysyx_040729_exe_mul_ctrl.md
Name: ysyx_040729_exe_mul_ctrl

Overview:
- EXE-stage initiator for the shared iterative multiplier; the multiplier is the responder on the same handshake.
- Accepts a decoded RV64M multiply op with its two operands and translates it into the multiplier's valid/ready/flush handshake.
- Captures result_hi/result_lo, selects and sign-adjusts the architectural result, and holds it for writeback under back-pressure.
- Drives the pipeline stall while a multiply is outstanding.

Parameters:
- XLEN, 64, operand/result width; the multiplier is instantiated with the same width.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- op_valid  input  1  EXE holds a multiply op
- op_type  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW; 101–111 treated as MUL
- src1  input  XLEN  rs1 value
- src2  input  XLEN  rs2 value
- flush  input  1  pipeline flush; cancels the op
- wb_ready  input  1  writeback accepts res_data this cycle
- op_ready  output  1  controller idle and can take an op
- stall  output  1  hold EXE and earlier stages
- res_valid  output  1  res_data valid
- res_data  output  XLEN  final rd value
- mul_valid  output  1  request to multiplier
- mul_flush  output  1  cancel to multiplier
- mulw  output  1  32-bit multiply
- mul_signed  output  2  11 s×s, 10 s×u, 00 u×u
- multiplicand  output  XLEN  operand A (src1)
- multiplier  output  XLEN  operand B (src2)
- mul_ready  input  1  multiplier can accept
- mul_out_valid  input  1  multiplier result valid
- result_hi  input  XLEN  upper product half
- result_lo  input  XLEN  lower product half

Behaviour:
- Reset (async, reset=0): state IDLE, all registers cleared.
  - Outputs during reset: op_ready=1; res_valid, mul_valid, mul_flush, stall = 0; res_data = 0.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - op_ready=1.
  - On op_valid & ~flush: latch op_type, src1, src2.
  - If the effective operand is zero, skip the multiplier: load res=0 and go to HOLD. Effective operand is src[31:0] when MULW, else the full src.
  - Otherwise go to ISSUE.
- ISSUE:
  - mul_valid=1, driven from registers only.
  - mulw=1 iff MULW.
  - mul_signed: MUL 11, MULH 11, MULHSU 10, MULHU 00, MULW 11.
  - multiplicand/multiplier come from the latched operands and are held stable until acceptance.
  - mul_valid & mul_ready → WAIT. mul_valid must be 0 in the following cycle.
- WAIT:
  - mul_valid=0.
  - On mul_out_valid: register res and go to HOLD. The result is sampled in exactly the cycle mul_out_valid is 1.
  - res selection:
    - MUL → result_lo.
    - MULH, MULHSU, MULHU → result_hi.
    - MULW → sign-extend result_lo[31:0] to XLEN.
- HOLD:
  - res_valid=1; res_data held constant.
  - wb_ready → IDLE. No new op is accepted in that same cycle.
- stall = (IDLE & op_valid & ~flush) | ISSUE | WAIT | (HOLD & ~wb_ready).
- Latency:
  - Zero shortcut: res_valid in the cycle after acceptance.
  - Normal path: res_valid in the cycle after mul_out_valid.
- flush (highest priority, any state): next state IDLE, res_valid=0 next cycle, result discarded.
  - mul_flush=1 for exactly that cycle if the state is ISSUE or WAIT; otherwise 0.
  - flush & op_valid in IDLE: op dropped, stall=0.
  - flush in the same cycle as mul_out_valid: result discarded.
- Async reset mid-operation: FSM returns to IDLE immediately. The multiplier is reset by the same reset; no mul_flush is required.
- mul_out_valid outside WAIT is ignored.

Test Plan:
- MUL src1=3, src2=5 → mul_valid one cycle with mul_signed=11, mulw=0 → res_valid with res_data=15; stall drops when wb_ready=1.
- src1=0xFFFF_FFFF_FFFF_FFFF, src2=2 →
  - MULH res_data=0xFFFF_FFFF_FFFF_FFFF;
  - MULHU res_data=0x1;
  - MULHSU res_data=0xFFFF_FFFF_FFFF_FFFF with mul_signed=10.
- MULW src1=0x1234_5678_7FFF_FFFF, src2=2 → mulw=1, res_data=0xFFFF_FFFF_FFFF_FFFE (upper src bits ignored).
- Zero shortcut: MUL src2=0 → mul_valid never 1, res_valid=1 in the cycle after acceptance, res_data=0. MULW with src1=0xFFFF_FFFF_0000_0000 takes the same shortcut.
- Hold mul_ready=0 for 4 cycles in ISSUE → mul_valid and operands stable; then flush in WAIT → mul_flush one cycle, no res_valid, next MUL 7×6 returns 42.
- wb_ready low 3 cycles in HOLD → res_data stable, stall=1. Assert reset=0 asynchronously mid-WAIT → immediately op_ready=1 and res_valid, mul_valid, stall = 0.
